// File: rtl/pkg_dtypes.sv
// Shared data types for the front-end icon path.
//   type_icon_instr : instruction word carried from rename to the icon controller
//   ICON_DQ_DEPTH   : default entry count of front_icon_dispatch_queue
package pkg_dtypes;

    localparam int unsigned ICON_OP_W      = 8;
    localparam int unsigned ICON_OPERAND_W = 24;
    localparam int unsigned ICON_DQ_DEPTH  = 8;

    typedef struct packed {
        logic [ICON_OP_W-1:0]      op;
        logic [ICON_OPERAND_W-1:0] operand;
    } type_icon_instr;

endpackage

// File: rtl/front_icon_dq_rank.sv
// Prefix rank of a lane mask: rank[i] = number of set bits below bit i,
// total = number of set bits. Purely combinational; used for both write-side
// lane compaction and read-side channel-to-entry mapping.
// Ports:
//   mask  : per-lane/per-channel request bits
//   rank  : prefix count per lane
//   total : popcount of mask
module front_icon_dq_rank #(
    parameter int unsigned NUM_ICON_CHANNELS = 4,
    localparam int unsigned RANK_W = $clog2(NUM_ICON_CHANNELS + 1)
) (
    input  logic [NUM_ICON_CHANNELS-1:0] mask,
    output logic [RANK_W-1:0]            rank [NUM_ICON_CHANNELS],
    output logic [RANK_W-1:0]            total
);

    logic [RANK_W-1:0] acc;

    // Running sum across lanes, lowest index first
    always_comb begin
        acc = '0;
        for (int i = 0; i < int'(NUM_ICON_CHANNELS); i++) begin
            rank[i] = acc;
            acc     = acc + RANK_W'(mask[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/front_icon_dispatch_queue.sv
// Multi-lane circular dispatch queue between rename and the backend icon
// controller. Accepts a whole batch of up to NUM_ICON_CHANNELS instructions
// when there is room for a full batch, compacts valid lanes, and hands the
// oldest entries to the lowest-indexed ready channels. No push-to-pop bypass.
// DEPTH must be a power of 2 and >= NUM_ICON_CHANNELS.
// Optional statistics (peak occupancy, stall cycles) enabled by the macro
// ICON_DQ_STATS_EN; otherwise those ports read 0.
// Ports:
//   clk, reset_n                 : clock, async active-low reset
//   flush_i                      : synchronous clear, wins over push/pop
//   icon_instr_i/_valid_i        : input lanes from rename
//   icon_instr_ready_o           : batch accepted this cycle
//   icon_instr_dispatch_o/_valid_o, icon_instr_dispatch_ready_i : per channel
//   occupancy_o, peak_occupancy_o, stall_cycles_o : status
module front_icon_dispatch_queue
    import pkg_dtypes::*;
#(
    parameter int unsigned NUM_ICON_CHANNELS = 4,
    parameter int unsigned DEPTH             = ICON_DQ_DEPTH,
    localparam int unsigned PTR_W            = $clog2(DEPTH),
    localparam int unsigned CNT_W            = PTR_W + 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush_i,
    input  type_icon_instr               icon_instr_i [NUM_ICON_CHANNELS],
    input  logic [NUM_ICON_CHANNELS-1:0] icon_instr_valid_i,
    output logic                         icon_instr_ready_o,
    output type_icon_instr               icon_instr_dispatch_o [NUM_ICON_CHANNELS],
    output logic [NUM_ICON_CHANNELS-1:0] icon_instr_dispatch_valid_o,
    input  logic [NUM_ICON_CHANNELS-1:0] icon_instr_dispatch_ready_i,
    output logic [CNT_W-1:0]             occupancy_o,
    output logic [CNT_W-1:0]             peak_occupancy_o,
    output logic [15:0]                  stall_cycles_o
);

    localparam int unsigned RANK_W = $clog2(NUM_ICON_CHANNELS + 1);

    type_icon_instr    mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [CNT_W-1:0]  push_cnt;
    logic [CNT_W-1:0]  pop_cnt;
    logic [RANK_W-1:0] lane_rank  [NUM_ICON_CHANNELS];
    logic [RANK_W-1:0] chan_rank  [NUM_ICON_CHANNELS];
    logic [RANK_W-1:0] push_total;
    logic [RANK_W-1:0] ready_total;

    front_icon_dq_rank #(.NUM_ICON_CHANNELS(NUM_ICON_CHANNELS)) u_push_rank (
        .mask  (icon_instr_valid_i),
        .rank  (lane_rank),
        .total (push_total)
    );

    front_icon_dq_rank #(.NUM_ICON_CHANNELS(NUM_ICON_CHANNELS)) u_pop_rank (
        .mask  (icon_instr_dispatch_ready_i),
        .rank  (chan_rank),
        .total (ready_total)
    );

    // Room for a full batch, from registered count only
    assign icon_instr_ready_o = !flush_i &&
        ((CNT_W'(DEPTH) - count_q) >= CNT_W'(NUM_ICON_CHANNELS));
    assign occupancy_o = count_q;

    // Push/pop amounts and next count
    always_comb begin
        push_cnt = '0;
        pop_cnt  = '0;
        if (icon_instr_ready_o) begin
            push_cnt = CNT_W'(push_total);
        end
        if (!flush_i) begin
            pop_cnt = (CNT_W'(ready_total) < count_q) ? CNT_W'(ready_total) : count_q;
        end
        count_d = count_q + push_cnt - pop_cnt;
    end

    // Channel c reads head + (ready channels below c); invalid channels drive 0
    always_comb begin
        for (int c = 0; c < int'(NUM_ICON_CHANNELS); c++) begin
            icon_instr_dispatch_valid_o[c] = !flush_i && icon_instr_dispatch_ready_i[c] &&
                                             (count_q > CNT_W'(chan_rank[c]));
            icon_instr_dispatch_o[c] = '0;
            if (icon_instr_dispatch_valid_o[c]) begin
                icon_instr_dispatch_o[c] = mem_q[head_q + PTR_W'(chan_rank[c])];
            end
        end
    end

    // Pointer and count state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PTR_W'(pop_cnt);
            tail_q  <= tail_q + PTR_W'(push_cnt);
            count_q <= count_d;
        end
    end

    // Storage: valid lanes land contiguously from tail; contents need no reset
    always_ff @(posedge clk) begin
        if (icon_instr_ready_o) begin
            for (int i = 0; i < int'(NUM_ICON_CHANNELS); i++) begin
                if (icon_instr_valid_i[i]) begin
                    mem_q[tail_q + PTR_W'(lane_rank[i])] <= icon_instr_i[i];
                end
            end
        end
    end

`ifdef ICON_DQ_STATS_EN
    logic [CNT_W-1:0] peak_q;
    logic [15:0]      stall_q;

    // High watermark survives flush; stall counter saturates
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            peak_q  <= '0;
            stall_q <= '0;
        end else begin
            if (!flush_i && (count_d > peak_q)) begin
                peak_q <= count_d;
            end
            if ((|icon_instr_valid_i) && !icon_instr_ready_o && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign peak_occupancy_o = peak_q;
    assign stall_cycles_o   = stall_q;
`else
    assign peak_occupancy_o = '0;
    assign stall_cycles_o   = '0;
`endif

endmodule

// File: tb/tb_front_icon_dispatch_queue.sv
// Directed bench for front_icon_dispatch_queue (4 channels, 8 entries).
// Statistics expectations follow ICON_DQ_STATS_EN.
module tb_front_icon_dispatch_queue;
    import pkg_dtypes::*;

    localparam int unsigned N = 4;
    localparam int unsigned D = 8;
`ifdef ICON_DQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic           clk;
    logic           reset_n;
    logic           flush_i;
    type_icon_instr instr [N];
    logic [N-1:0]   valid;
    logic           ready_o;
    type_icon_instr disp [N];
    logic [N-1:0]   disp_valid;
    logic [N-1:0]   disp_ready;
    logic [3:0]     occ;
    logic [3:0]     peak;
    logic [15:0]    stall;
    type_icon_instr nul;

    int checks;
    int errors;

    front_icon_dispatch_queue #(.NUM_ICON_CHANNELS(N), .DEPTH(D)) dut (
        .clk                         (clk),
        .reset_n                     (reset_n),
        .flush_i                     (flush_i),
        .icon_instr_i                (instr),
        .icon_instr_valid_i          (valid),
        .icon_instr_ready_o          (ready_o),
        .icon_instr_dispatch_o       (disp),
        .icon_instr_dispatch_valid_o (disp_valid),
        .icon_instr_dispatch_ready_i (disp_ready),
        .occupancy_o                 (occ),
        .peak_occupancy_o            (peak),
        .stall_cycles_o              (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic type_icon_instr mk(input logic [7:0] tag);
        type_icon_instr r;
        r.op      = tag;
        r.operand = {tag, 8'h5A, tag};
        return r;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input type_icon_instr l0, input type_icon_instr l1,
                             input type_icon_instr l2, input type_icon_instr l3,
                             input logic [N-1:0] v);
        instr[0] = l0;
        instr[1] = l1;
        instr[2] = l2;
        instr[3] = l3;
        valid    = v;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        flush_i = 1'b0;
        disp_ready = '0;
        set_lanes(nul, nul, nul, nul, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (occ !== 4'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occ); end
        disp_ready = 4'b1111;
        #1;
        checks++; if (disp_valid !== 4'b0000) begin errors++; $display("FAIL reset_disp_valid got %b want 0000", disp_valid); end
        checks++; if (peak !== 4'd0) begin errors++; $display("FAIL reset_peak got %0d want 0", peak); end
        checks++; if (stall !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall); end
        disp_ready = '0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_o); end
        step;
    endtask

    task automatic test_write_compaction;
        set_lanes(mk(8'h0A), mk(8'h0B), mk(8'h0C), mk(8'h0D), 4'b1101);
        step;
        valid = '0;
        @(negedge clk);
        checks++; if (occ !== 4'd3) begin errors++; $display("FAIL compact_occ got %0d want 3", occ); end
        disp_ready = 4'b1111;
        #1;
        checks++; if (disp_valid !== 4'b0111) begin errors++; $display("FAIL compact_valid got %b want 0111", disp_valid); end
        checks++; if (disp[0] !== mk(8'h0A)) begin errors++; $display("FAIL compact_e0 got %h want %h", disp[0], mk(8'h0A)); end
        checks++; if (disp[1] !== mk(8'h0C)) begin errors++; $display("FAIL compact_e1 got %h want %h", disp[1], mk(8'h0C)); end
        checks++; if (disp[2] !== mk(8'h0D)) begin errors++; $display("FAIL compact_e2 got %h want %h", disp[2], mk(8'h0D)); end
        checks++; if (disp[3] !== nul) begin errors++; $display("FAIL compact_e3_zero got %h want 0", disp[3]); end
        disp_ready = '0;
        step;
        set_lanes(mk(8'h0E), mk(8'h0F), mk(8'h10), mk(8'h11), 4'b1111);
        step;
        valid = '0;
        @(negedge clk);
        checks++; if (occ !== 4'd7) begin errors++; $display("FAIL fill_occ got %0d want 7", occ); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL fill_ready got %b want 0", ready_o); end
        step;
    endtask

    task automatic test_stats;
        set_lanes(mk(8'h7F), nul, nul, nul, 4'b0001);
        repeat (3) step;
        valid = '0;
        @(negedge clk);
        checks++; if (occ !== 4'd7) begin errors++; $display("FAIL stall_occ got %0d want 7", occ); end
        checks++; if (stall !== (STATS ? 16'd3 : 16'd0)) begin errors++; $display("FAIL stall_cycles got %0d want %0d", stall, STATS ? 3 : 0); end
        checks++; if (peak !== (STATS ? 4'd7 : 4'd0)) begin errors++; $display("FAIL peak got %0d want %0d", peak, STATS ? 7 : 0); end
        step;
    endtask

    task automatic test_pop_ordering;
        disp_ready = 4'b1010;
        @(negedge clk);
        checks++; if (disp_valid !== 4'b1010) begin errors++; $display("FAIL pop_valid got %b want 1010", disp_valid); end
        checks++; if (disp[1] !== mk(8'h0A)) begin errors++; $display("FAIL pop_ch1 got %h want %h", disp[1], mk(8'h0A)); end
        checks++; if (disp[3] !== mk(8'h0C)) begin errors++; $display("FAIL pop_ch3 got %h want %h", disp[3], mk(8'h0C)); end
        checks++; if (disp[0] !== nul || disp[2] !== nul) begin errors++; $display("FAIL pop_idle_zero got %h %h want 0", disp[0], disp[2]); end
        step;
        disp_ready = '0;
        @(negedge clk);
        checks++; if (occ !== 4'd5) begin errors++; $display("FAIL pop_occ got %0d want 5", occ); end
        step;
    endtask

    task automatic test_back_to_back;
        disp_ready = 4'b0001;
        @(negedge clk);
        checks++; if (disp[0] !== mk(8'h0D)) begin errors++; $display("FAIL b2b_pre got %h want %h", disp[0], mk(8'h0D)); end
        step;
        disp_ready = '0;
        @(negedge clk);
        checks++; if (occ !== 4'd4 || ready_o !== 1'b1) begin errors++; $display("FAIL b2b_occ got %0d/%b want 4/1", occ, ready_o); end
        set_lanes(mk(8'h12), mk(8'h13), mk(8'h14), mk(8'h15), 4'b1111);
        disp_ready = 4'b1111;
        #1;
        checks++; if (disp_valid !== 4'b1111) begin errors++; $display("FAIL b2b_valid got %b want 1111", disp_valid); end
        checks++; if (disp[0] !== mk(8'h0E) || disp[3] !== mk(8'h11)) begin errors++; $display("FAIL b2b_old got %h %h want %h %h", disp[0], disp[3], mk(8'h0E), mk(8'h11)); end
        step;
        valid = '0;
        disp_ready = '0;
        @(negedge clk);
        checks++; if (occ !== 4'd4) begin errors++; $display("FAIL b2b_count got %0d want 4", occ); end
        disp_ready = 4'b1111;
        #1;
        checks++; if (disp[0] !== mk(8'h12) || disp[1] !== mk(8'h13) || disp[2] !== mk(8'h14) || disp[3] !== mk(8'h15))
            begin errors++; $display("FAIL b2b_order got %h %h %h %h want I J K L", disp[0], disp[1], disp[2], disp[3]); end
        step;
        disp_ready = '0;
        @(negedge clk);
        checks++; if (occ !== 4'd0) begin errors++; $display("FAIL b2b_drain got %0d want 0", occ); end
        step;
    endtask

    task automatic test_wrap;
        set_lanes(mk(8'h16), mk(8'h17), mk(8'h18), nul, 4'b0111);
        step;
        valid = '0;
        disp_ready = 4'b1111;
        @(negedge clk);
        checks++; if (disp_valid !== 4'b0111 || disp[2] !== mk(8'h18) || disp[3] !== nul)
            begin errors++; $display("FAIL wrap_pre got %b %h %h want 0111 %h 0", disp_valid, disp[2], disp[3], mk(8'h18)); end
        step;
        disp_ready = '0;
        set_lanes(mk(8'h19), mk(8'h1A), mk(8'h1B), mk(8'h1C), 4'b1111);
        step;
        valid = '0;
        disp_ready = 4'b1111;
        @(negedge clk);
        checks++; if (disp_valid !== 4'b1111) begin errors++; $display("FAIL wrap_valid got %b want 1111", disp_valid); end
        checks++; if (disp[0] !== mk(8'h19) || disp[1] !== mk(8'h1A) || disp[2] !== mk(8'h1B) || disp[3] !== mk(8'h1C))
            begin errors++; $display("FAIL wrap_order got %h %h %h %h want P Q R S", disp[0], disp[1], disp[2], disp[3]); end
        step;
        disp_ready = '0;
    endtask

    task automatic test_flush;
        set_lanes(mk(8'h20), mk(8'h21), mk(8'h22), mk(8'h23), 4'b1111);
        step;
        set_lanes(mk(8'h24), nul, nul, nul, 4'b0001);
        step;
        valid = '0;
        @(negedge clk);
        checks++; if (occ !== 4'd5) begin errors++; $display("FAIL flush_pre got %0d want 5", occ); end
        flush_i = 1'b1;
        set_lanes(mk(8'h30), mk(8'h31), mk(8'h32), mk(8'h33), 4'b1111);
        disp_ready = 4'b1111;
        #1;
        checks++; if (disp_valid !== 4'b0000 || ready_o !== 1'b0) begin errors++; $display("FAIL flush_gate got %b/%b want 0000/0", disp_valid, ready_o); end
        step;
        flush_i = 1'b0;
        valid = '0;
        @(negedge clk);
        checks++; if (occ !== 4'd0 || disp_valid !== 4'b0000) begin errors++; $display("FAIL flush_clear got %0d/%b want 0/0000", occ, disp_valid); end
        checks++; if (peak !== (STATS ? 4'd7 : 4'd0)) begin errors++; $display("FAIL flush_peak got %0d want %0d", peak, STATS ? 7 : 0); end
        checks++; if (stall !== (STATS ? 16'd4 : 16'd0)) begin errors++; $display("FAIL flush_stall got %0d want %0d", stall, STATS ? 4 : 0); end
        disp_ready = '0;
        step;
        set_lanes(mk(8'h40), nul, nul, nul, 4'b0001);
        step;
        valid = '0;
        disp_ready = 4'b1111;
        @(negedge clk);
        checks++; if (disp_valid !== 4'b0001 || disp[0] !== mk(8'h40)) begin errors++; $display("FAIL flush_after got %b %h want 0001 %h", disp_valid, disp[0], mk(8'h40)); end
        step;
        disp_ready = '0;
    endtask

    task automatic test_reset_mid;
        set_lanes(mk(8'h50), mk(8'h51), mk(8'h52), mk(8'h53), 4'b1111);
        step;
        valid = '0;
        @(negedge clk);
        checks++; if (occ !== 4'd4) begin errors++; $display("FAIL rmid_pre got %0d want 4", occ); end
        reset_n = 1'b0;
        disp_ready = 4'b1111;
        #1;
        checks++; if (occ !== 4'd0 || disp_valid !== 4'b0000) begin errors++; $display("FAIL rmid_async got %0d/%b want 0/0000", occ, disp_valid); end
        checks++; if (peak !== 4'd0 || stall !== 16'd0) begin errors++; $display("FAIL rmid_stats got %0d/%0d want 0/0", peak, stall); end
        disp_ready = '0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        set_lanes(mk(8'h60), nul, nul, nul, 4'b0001);
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", ready_o); end
        step;
        valid = '0;
        disp_ready = 4'b0001;
        @(negedge clk);
        checks++; if (occ !== 4'd1 || disp[0] !== mk(8'h60)) begin errors++; $display("FAIL rmid_push got %0d %h want 1 %h", occ, disp[0], mk(8'h60)); end
        step;
        disp_ready = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nul = '0;
        test_reset;
        test_write_compaction;
        test_stats;
        test_pop_ordering;
        test_back_to_back;
        test_wrap;
        test_flush;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
